unidade_controle: RTL

Moore-style control unit that sequences the GeoGenius datapath (`fluxo_de_dados`) through a full game. For each round it loads the flag for the current round from ROM and shows it, waits for a button press or a difficulty-dependent timeout, then registers and compares the play. It scores a correct answer, holds the result display for the result timer, and advances until the last round. It sits between the top-level user inputs (`iniciar`) and the datapath's control/condition ports.

---
 rtl/unidade_controle.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/unidade_controle.sv
// GeoGenius control unit: Moore FSM that sequences fluxo_de_dados through a game.
// Define GEOGENIUS_TIMEOUT_EN to let ESPERA end a round on deu_timeout.
module unidade_controle (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       fez_jogada,
    input  logic       jogada_igual_memoria,
    input  logic       deu_timeout,
    input  logic       fim_timer_resultado,
    input  logic       ultima_jogada,
    output logic       zera_contador_jogada,
    output logic       zera_contador_score,
    output logic       zera_timer_resultado,
    output logic       zera_timeout,
    output logic       zeraR,
    output logic       conta_jogada,
    output logic       conta_score,
    output logic       conta_timer_resultado,
    output logic       conta_timeout,
    output logic       registraR,
    output logic       liga_led,
    output logic       acertou,
    output logic       timeout_ocorreu,
    output logic       pronto,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL   = 4'd0,
        PREPARA   = 4'd1,
        CARREGA   = 4'd2,
        ESPERA    = 4'd3,
        REGISTRA  = 4'd4,
        COMPARA   = 4'd5,
        ACERTOU   = 4'd6,
        ERROU     = 4'd7,
        RESULTADO = 4'd8,
        PROXIMA   = 4'd9,
        FIM       = 4'd10
    } estado_t;

    logic [3:0] estado;
    estado_t    proximo;
    logic       timeout_ok;

`ifdef GEOGENIUS_TIMEOUT_EN
    assign timeout_ok = deu_timeout;
`else
    logic unused_deu_timeout;
    assign unused_deu_timeout = deu_timeout;
    assign timeout_ok = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) estado <= INICIAL;
        else        estado <= proximo;
    end

    always_comb begin
        proximo = INICIAL;
        case (estado)
            INICIAL:   proximo = iniciar ? PREPARA : INICIAL;
            PREPARA:   proximo = CARREGA;
            CARREGA:   proximo = ESPERA;
            // a press in the same cycle as the timeout still counts as a play
            ESPERA:    proximo = fez_jogada ? REGISTRA : (timeout_ok ? ERROU : ESPERA);
            REGISTRA:  proximo = COMPARA;
            COMPARA:   proximo = jogada_igual_memoria ? ACERTOU : ERROU;
            ACERTOU:   proximo = RESULTADO;
            ERROU:     proximo = RESULTADO;
            RESULTADO: proximo = fim_timer_resultado ? (ultima_jogada ? FIM : PROXIMA) : RESULTADO;
            PROXIMA:   proximo = CARREGA;
            FIM:       proximo = iniciar ? PREPARA : FIM;
            default:   proximo = INICIAL;
        endcase
    end

    always_comb begin
        zera_contador_jogada  = 1'b0;
        zera_contador_score   = 1'b0;
        zera_timer_resultado  = 1'b0;
        zera_timeout          = 1'b0;
        zeraR                 = 1'b0;
        conta_jogada          = 1'b0;
        conta_score           = 1'b0;
        conta_timer_resultado = 1'b0;
        conta_timeout         = 1'b0;
        registraR             = 1'b0;
        liga_led              = 1'b0;
        pronto                = 1'b0;
        case (estado)
            PREPARA: begin
                zera_contador_jogada = 1'b1;
                zera_contador_score  = 1'b1;
                zera_timer_resultado = 1'b1;
                zera_timeout         = 1'b1;
                zeraR                = 1'b1;
            end
            CARREGA: begin
                zera_timeout = 1'b1;
                zeraR        = 1'b1;
            end
            ESPERA: begin
                liga_led      = 1'b1;
                conta_timeout = 1'b1;
            end
            REGISTRA: begin
                registraR = 1'b1;
                liga_led  = 1'b1;
            end
            COMPARA:  liga_led = 1'b1;
            ACERTOU: begin
                conta_score          = 1'b1;
                zera_timer_resultado = 1'b1;
            end
            ERROU:    zera_timer_resultado = 1'b1;
            RESULTADO: begin
                conta_timer_resultado = 1'b1;
                liga_led              = 1'b1;
            end
            PROXIMA:  conta_jogada = 1'b1;
            FIM:      pronto = 1'b1;
            default: ;
        endcase
    end

    // result flags persist through RESULTADO and FIM so the display can show them
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acertou         <= 1'b0;
            timeout_ocorreu <= 1'b0;
        end else begin
            case (estado)
                PREPARA: begin
                    acertou         <= 1'b0;
                    timeout_ocorreu <= 1'b0;
                end
                ESPERA: begin
                    if (!fez_jogada && timeout_ok) timeout_ocorreu <= 1'b1;
                end
                ACERTOU: begin
                    acertou         <= 1'b1;
                    timeout_ocorreu <= 1'b0;
                end
                ERROU:   acertou <= 1'b0;
                default: ;
            endcase
        end
    end

    assign db_estado = estado;

endmodule
